// File: rtl/filo_reverser.sv
// Stream reversal controller: pushes a packet (or FILO_DEPTH-beat chunk) into
// the attached stack, then pops it back out so the beats leave in reverse order.
//
// state | meaning
// ------+------------------------------------------------------------
// FILL  | accepting input beats and pushing them onto the stack
// DRAIN | popping the stack to the output stream until it is empty
module filo_reverser #(
  parameter int DATA_WIDTH = 8,
  parameter int FILO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  f_wr_en,
  output logic [DATA_WIDTH-1:0] f_wr_data,
  input  logic                  f_wr_ready,
  output logic                  f_rd_en,
  input  logic [DATA_WIDTH-1:0] f_rd_data,
  input  logic                  f_rd_val,
  output logic                  err
);

  localparam int CW = $clog2(FILO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FILO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic {FILL, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            chunk_last_q, chunk_last_d;
  logic            m_valid_q, m_valid_d;
  logic            m_last_q, m_last_d;
  logic            err_q, err_d;
  logic            out_hs;
  logic            err_set;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    chunk_last_d = chunk_last_q;
    m_valid_d    = m_valid_q;
    m_last_d     = m_last_q;
    s_ready      = 1'b0;
    f_wr_en      = 1'b0;
    f_rd_en      = 1'b0;
    out_hs       = m_valid_q && m_ready;

    case (state_q)
      FILL: begin
        s_ready = f_wr_ready && (cnt_q < DEPTH_C);
        f_wr_en = s_valid && s_ready;
        if (f_wr_en) begin
          cnt_d = cnt_q + ONE_C;
          // A full stack closes the chunk even without s_last.
          if (s_last || ((cnt_q + ONE_C) == DEPTH_C)) begin
            state_d      = DRAIN;
            chunk_last_d = s_last;
          end
        end
      end
      DRAIN: begin
        f_rd_en = (cnt_q != '0) && (!m_valid_q || m_ready);
        if (f_rd_en) begin
          cnt_d    = cnt_q - ONE_C;
          m_last_d = chunk_last_q && (cnt_q == ONE_C);
        end
        if (out_hs && (m_last_q || (cnt_q == '0))) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    if (f_rd_en) begin
      m_valid_d = 1'b1;
    end else if (out_hs) begin
      m_valid_d = 1'b0;
    end

    // A presented beat without matching stack pop-valid means underflow/desync.
    err_set = m_valid_q && !f_rd_val;
    err_d   = err_q || err_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      chunk_last_q <= 1'b0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      chunk_last_q <= chunk_last_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      err_q        <= err_d;
    end
  end

  // The stack holds its pop data between pops, so data passes straight through.
  assign m_data    = f_rd_data;
  assign f_wr_data = s_data;
  assign m_valid   = m_valid_q;
  assign m_last    = m_last_q;
  assign err       = err_q || err_set;

endmodule
